// File: rtl/tt3_response_checker_pkg.sv
// Shared definitions for the tt-style response checkers.
//   state_t        : checker FSM state encoding (IDLE/CHECK/DONE)
//   TT_DEFAULT     : default expected truth table, f=1 only for minterms 2 and 3
//   minterm_mask() : one-hot mask for a 3-bit minterm index
package tt3_response_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] TT_DEFAULT = 8'h0C;

  function automatic logic [7:0] minterm_mask(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/tt3_response_checker_if.sv
// Stimulus/response bus observed by the checker.
//   start    : one-cycle pulse, begins a new check run
//   in_valid : x,y,z,f are stable and must be sampled this cycle
//   x,y,z    : applied stimulus bits 2,1,0
//   f        : DUT response for {x,y,z}
// master drives the bus (stimulus side), slave observes it (checker).
interface tt3_response_checker_if;
  logic start;
  logic in_valid;
  logic x;
  logic y;
  logic z;
  logic f;

  modport master (output start, in_valid, x, y, z, f);
  modport slave  (input  start, in_valid, x, y, z, f);
endinterface

// File: rtl/tt3_response_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (wins over inc)
//   inc        : increment by one, holding at all-ones
//   q          : count value
module tt3_response_checker_sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/tt3_response_checker.sv
// Response checker for 3-input gate-level benches. Samples {x,y,z} and f on
// in_valid while in CHECK, compares f to EXPECT_TT[{x,y,z}], tracks minterm
// coverage, counts mismatches and captures the first failing vector. Ends the
// run on full coverage or after TIMEOUT CHECK cycles.
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus              : start / in_valid / x / y / z / f (slave side)
//   busy             : in CHECK
//   done             : in DONE, held until the next start
//   pass             : coverage complete and zero mismatches (valid with done)
//   timed_out        : run ended without full coverage (valid with done)
//   err_count        : saturating mismatch count
//   cov_map          : bit k set once minterm k has been sampled
//   first_fail_valid : a mismatch has been captured
//   first_fail_vec   : {x,y,z} of the first mismatch
module tt3_response_checker
  import tt3_response_checker_pkg::*;
#(
  parameter logic [7:0]  EXPECT_TT = TT_DEFAULT,
  parameter int unsigned ERR_W     = 4,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned TO_W      = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tt3_response_checker_if.slave  bus,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timed_out,
  output logic [ERR_W-1:0]       err_count,
  output logic [7:0]             cov_map,
  output logic                   first_fail_valid,
  output logic [2:0]             first_fail_vec
);

  state_t          state;
  state_t          state_nxt;
  logic            clr;
  logic            finish;
  logic            sample;
  logic            mismatch;
  logic [2:0]      idx;
  logic [7:0]      cov_nxt;
  logic            cov_full;
  logic            err_zero_nxt;
  logic            tmo_hit;
  logic [TO_W-1:0] tmo_q;

  assign idx      = {bus.x, bus.y, bus.z};
  assign sample   = (state == ST_CHECK) && bus.in_valid;
  assign mismatch = sample && (bus.f != EXPECT_TT[idx]);
  assign cov_nxt  = sample ? (cov_map | minterm_mask(idx)) : cov_map;
  assign cov_full = (cov_nxt == 8'hFF);
  // Incrementing from zero can never land back on zero, so the post-edge
  // count is zero exactly when it is zero now and this sample matches.
  assign err_zero_nxt = (err_count == '0) && !mismatch;
  // The counter holds the number of completed CHECK cycles; the edge on which
  // it would reach TIMEOUT is the one that ends the run.
  assign tmo_hit  = (tmo_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          clr       = 1'b1;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cov_full || tmo_hit) begin
          finish    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_CHECK);
  assign done = (state == ST_DONE);

  tt3_response_checker_sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (mismatch),
    .q     (err_count)
  );

  tt3_response_checker_sat_counter #(.W(TO_W)) u_tmo_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (busy),
    .q     (tmo_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cov_map          <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      pass             <= 1'b0;
      timed_out        <= 1'b0;
    end else if (clr) begin
      cov_map          <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      pass             <= 1'b0;
      timed_out        <= 1'b0;
    end else begin
      cov_map <= cov_nxt;
      if (mismatch && !first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_vec   <= idx;
      end
      // Coverage wins a tie with the timeout, and the final sample counts.
      if (finish) begin
        pass      <= cov_full && err_zero_nxt;
        timed_out <= !cov_full;
      end
    end
  end

endmodule

// File: tb/tb_tt3_response_checker.sv
module tb_tt3_response_checker;

  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tt3_response_checker_if bus ();

  logic       busy_a, done_a, pass_a, to_a, ffv_a;
  logic [3:0] err_a;
  logic [7:0] cov_a;
  logic [2:0] ffvec_a;

  logic       busy_b, done_b, pass_b, to_b, ffv_b;
  logic [1:0] err_b;
  logic [7:0] cov_b;
  logic [2:0] ffvec_b;

  tt3_response_checker #(.EXPECT_TT(8'h0C), .ERR_W(4), .TIMEOUT(TIMEOUT), .TO_W(7)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .busy(busy_a), .done(done_a), .pass(pass_a), .timed_out(to_a),
    .err_count(err_a), .cov_map(cov_a),
    .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
  );

  tt3_response_checker #(.EXPECT_TT(8'h0C), .ERR_W(2), .TIMEOUT(TIMEOUT), .TO_W(7)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .busy(busy_b), .done(done_b), .pass(pass_b), .timed_out(to_b),
    .err_count(err_b), .cov_map(cov_b),
    .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
  );

  int tests = 0;
  int failed = 0;

  // Reference model: run flag, per-minterm seen flags, raw mismatch total,
  // first failing index (-1 when none), and cycles spent checking.
  logic [7:0] exp_tt = 8'h0C;
  bit m_run, m_done, m_pass, m_to;
  bit m_seen[8];
  int m_errs, m_ff, m_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_seen[i] = 0;
    m_errs = 0;
    m_ff   = -1;
    m_cyc  = 0;
    m_pass = 0;
    m_to   = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_run  = 0;
    m_done = 0;
  endtask

  function automatic bit all_seen();
    bit a = 1;
    for (int i = 0; i < 8; i++) a &= m_seen[i];
    return a;
  endfunction

  task automatic compare_all();
    logic [7:0] cov;
    int cap_a, cap_b;
    cov = '0;
    for (int i = 0; i < 8; i++) if (m_seen[i]) cov[i] = 1'b1;
    cap_a = (m_errs > 15) ? 15 : m_errs;
    cap_b = (m_errs > 3) ? 3 : m_errs;
    check("busy",       32'(busy_a),  32'(m_run));
    check("done",       32'(done_a),  32'(m_done));
    check("pass",       32'(pass_a),  32'(m_pass));
    check("timed_out",  32'(to_a),    32'(m_to));
    check("err_count",  32'(err_a),   32'(cap_a));
    check("cov_map",    32'(cov_a),   32'(cov));
    check("ff_valid",   32'(ffv_a),   32'(m_ff >= 0));
    check("ff_vec",     32'(ffvec_a), (m_ff >= 0) ? 32'(m_ff) : 32'd0);
    check("err_sat2",   32'(err_b),   32'(cap_b));
    check("done_b",     32'(done_b),  32'(m_done));
  endtask

  task automatic step(input bit st, input bit v, input logic [2:0] idx, input bit fv);
    bus.start    = st;
    bus.in_valid = v;
    {bus.x, bus.y, bus.z} = idx;
    bus.f        = fv;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (m_run) begin
      m_cyc++;
      if (v) begin
        m_seen[idx] = 1;
        if (fv != exp_tt[idx]) begin
          m_errs++;
          if (m_ff < 0) m_ff = int'(idx);
        end
      end
      if (all_seen() || m_cyc == TIMEOUT) begin
        m_run  = 0;
        m_done = 1;
        m_pass = all_seen() && (m_errs == 0);
        m_to   = !all_seen();
      end
    end else if (st) begin
      model_clear();
      m_run  = 1;
      m_done = 0;
    end
    #1;
    compare_all();
  endtask

  task automatic sweep(input logic [7:0] bad);
    for (int i = 0; i < 8; i++) step(0, 1, 3'(i), exp_tt[i] ^ bad[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, 0);
  endtask

  initial begin
    logic [2:0] r_idx;
    model_reset();
    bus.start = 0; bus.in_valid = 0; bus.x = 0; bus.y = 0; bus.z = 0; bus.f = 0;
    #1;
    compare_all();
    idle(2);
    #2 rst_n = 1'b1;
    idle(2);

    // Correct sweep, then DONE must hold.
    step(1, 0, 3'd0, 0);
    sweep(8'h00);
    idle(3);

    // Stuck-at-0 response.
    step(1, 0, 3'd0, 0);
    sweep(exp_tt);
    idle(2);

    // Restart from DONE with one bad response at minterm 5.
    step(1, 1, 3'd7, 1);
    sweep(8'h20);
    idle(2);

    // Twelve mismatches over minterms 0..6 only, then run into the timeout.
    step(1, 0, 3'd0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 3'(i % 7), ~exp_tt[i % 7]);
    idle(TIMEOUT - 12 + 3);

    // Minterms 0..6 only, timeout must land exactly TIMEOUT cycles after start.
    step(1, 0, 3'd0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 3'(i), exp_tt[i]);
    idle(TIMEOUT - 7 + 2);

    // Asynchronous reset mid-run, then a clean run.
    step(1, 0, 3'd0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 3'(i), ~exp_tt[i]);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    step(0, 0, 3'd0, 0);
    #2 rst_n = 1'b1;
    step(1, 0, 3'd0, 0);
    step(1, 1, 3'd4, 0);
    sweep(8'h00);
    idle(2);

    // Randomized runs with gaps, repeats, stray starts and occasional errors.
    for (int r = 0; r < 20; r++) begin
      step(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 72; c++) begin
        r_idx = 3'($urandom_range(0, 7));
        step(($urandom_range(0, 29) == 0),
             ($urandom_range(0, 3) != 0),
             r_idx,
             exp_tt[r_idx] ^ ($urandom_range(0, 9) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/tt3_response_checker.md
Name: tt3_response_checker

Overview:
- Receive-side counterpart to the 3-input stimulus generators used across our gate-level example benches.
- Samples each applied vector {x,y,z} together with the DUT output f on a valid strobe and compares f against a parameterized 8-entry expected truth table.
- Tracks minterm coverage, counts mismatches and captures the first failing vector.
- Reports pass/fail once all 8 minterms are seen or a timeout expires; sits beside the DUT inside the testbench top.

Parameters:
- EXPECT_TT, 8'h0C, expected f per minterm; bit index = {x,y,z}. Default: f=1 only for 3'b010 and 3'b011.
- ERR_W, 4, width of the saturating mismatch counter.
- TIMEOUT, 64, cycles in CHECK without full coverage before the run is aborted. Must be >= 1.
- TO_W, 7, timeout counter width. Must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  input  1  sampling clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a new check run
- in_valid  input  1  x,y,z,f are stable and must be sampled this cycle
- x  input  1  applied stimulus bit 2
- y  input  1  applied stimulus bit 1
- z  input  1  applied stimulus bit 0
- f  input  1  DUT response for {x,y,z}
- busy  output  1  high while in CHECK
- done  output  1  high in DONE; held until the next start
- pass  output  1  valid when done: coverage complete and zero mismatches
- timed_out  output  1  valid when done: run ended by timeout
- err_count  output  ERR_W  mismatches; saturates at all-ones
- cov_map  output  8  bit k set once minterm k has been sampled
- first_fail_valid  output  1  a mismatch has been captured
- first_fail_vec  output  3  {x,y,z} of the first mismatch

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, done, pass, timed_out, first_fail_valid = 0; err_count, cov_map, first_fail_vec and the timeout counter = 0.
- FSM states: IDLE, CHECK, DONE.
  - IDLE -> CHECK on start.
  - CHECK -> DONE when cov_map becomes 8'hFF, or when the timeout counter reaches TIMEOUT.
  - DONE -> CHECK on start. Otherwise DONE holds.
- Entering CHECK, on the start edge in either IDLE or DONE, clears err_count, cov_map, first_fail_*, the timeout counter, done, pass and timed_out.
- start while already in CHECK is ignored.
- Sampling happens only in CHECK with in_valid=1.
  - Let idx = {x,y,z}. Set cov_map[idx].
  - If f != EXPECT_TT[idx], increment err_count, saturating at 2^ERR_W-1.
  - If first_fail_valid=0 on a mismatch, capture first_fail_vec=idx and set first_fail_valid=1.
- Repeated minterms are re-checked: each mismatch counts, and coverage stays set.
- All registered results update at the sampling edge, so outputs reflect a sample one cycle after in_valid.
- Timeout counter increments on every CHECK cycle, whether or not in_valid is high.
- If the completing sample and the timeout occur on the same edge, coverage wins: timed_out=0.
- The final sample is included in pass evaluation: it is counted even if it completes coverage.
- On entering DONE:
  - pass = (next cov_map==8'hFF) && (next err_count==0)
  - timed_out = (coverage incomplete)
  - done = 1
- In DONE, in_valid is ignored and all results are frozen.
- rst_n low mid-run aborts immediately: all outputs return to reset values and no result is reported.
- Any X/Z on x,y,z,f during a sample is outside this block's scope (no X detection).

Decomposition:
- Shared package/include: state encoding localparams (ST_IDLE=2'd0, ST_CHECK=2'd1, ST_DONE=2'd2) and the default expected-table constant, reused by future tt-checkers.
- One natural sub-module: sat_counter (width param, clear, inc, saturating). Used for both err_count and the timeout counter.

Test Plan:
- Correct DUT model: start, then drive minterms 0..7 in order, one per cycle with in_valid=1 and f=EXPECT_TT[idx] -> done=1 one cycle after the 8th sample; pass=1; err_count=0; cov_map=8'hFF; timed_out=0.
- Stuck-at-0 DUT (f=0 for all minterms) -> err_count=2; first_fail_vec=3'b010; pass=0; done after 8 samples.
- Only minterms 0..6 driven, then idle -> done at TIMEOUT=64 cycles after start; timed_out=1; cov_map=8'h7F; pass=0.
- ERR_W=2 with 12 mismatching samples -> err_count saturates at 3 and does not wrap.
- rst_n pulsed low after 4 samples -> all outputs clear asynchronously. A new start followed by a full correct sweep gives pass=1.
- Second start while in DONE, then a sweep with a single bad f at idx 5 -> previous results cleared; first_fail_vec=3'b101; err_count=1.
